// File: rtl/bcd_clock_scan_if.sv
// Control inputs, time readout and 7-segment drive of bcd_clock_scan, bundled as one port.
interface bcd_clock_scan_if;
    logic        run;
    logic        set_min;
    logic        set_hour;
    logic [23:0] time_bcd;
    logic        sec_tick;
    logic [7:0]  Cx;
    logic [7:0]  AN;

    modport master (output run, set_min, set_hour, input time_bcd, sec_tick, Cx, AN);
    modport slave  (input run, set_min, set_hour, output time_bcd, sec_tick, Cx, AN);
endinterface

// File: rtl/bcd_clock_scan.sv
// BCD HH:MM(:SS) time-of-day clock with a multiplexed active-low 7-segment scan driver.
// Define HOUR12_EN for 12-hour operation with an AM/PM indicator; default is 24-hour.
module bcd_clock_scan #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned SCAN_HZ    = 1000,
    parameter int unsigned NUM_DIGITS = 6
) (
    input logic             sysCLK,
    input logic             RST,
    bcd_clock_scan_if.slave bus
);
    localparam int unsigned SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int unsigned CW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned DW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [CW-1:0] CntLast = CW'(CLK_HZ - 1);
    localparam logic [CW-1:0] CntHalf = CW'(CLK_HZ / 2);
    localparam logic [DW-1:0] DivLast = DW'(SCAN_DIV - 1);
    localparam logic [2:0]    PosOffs = 3'(6 - NUM_DIGITS);

`ifdef HOUR12_EN
    // One extra scan slot drives AN[7] as the PM indicator.
    localparam logic [2:0] IdxLast = 3'(NUM_DIGITS);
    localparam logic [3:0] HtRst   = 4'd1;
    localparam logic [3:0] HoRst   = 4'd2;
`else
    localparam logic [2:0] IdxLast = 3'(NUM_DIGITS - 1);
    localparam logic [3:0] HtRst   = 4'd0;
    localparam logic [3:0] HoRst   = 4'd0;
`endif

    if (SCAN_DIV < 1) begin : g_bad_scan_div
        $error("bcd_clock_scan: CLK_HZ/SCAN_HZ must be at least 1");
    end
    if (NUM_DIGITS != 4 && NUM_DIGITS != 6) begin : g_bad_num_digits
        $error("bcd_clock_scan: NUM_DIGITS must be 4 or 6");
    end

    function automatic logic [7:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            default: seg7 = 8'hFF;
        endcase
    endfunction

    // Returns {h_t, h_o} after one hour step.
    function automatic logic [7:0] hour_next(input logic [3:0] ht, input logic [3:0] ho);
`ifdef HOUR12_EN
        if (ht == 4'd1 && ho == 4'd2) begin
            hour_next = {4'd0, 4'd1};
        end else if (ho == 4'd9) begin
            hour_next = {4'd1, 4'd0};
        end else begin
            hour_next = {ht, ho + 4'd1};
        end
`else
        if (ht == 4'd2 && ho == 4'd3) begin
            hour_next = 8'h00;
        end else if (ho == 4'd9) begin
            hour_next = {ht + 4'd1, 4'd0};
        end else begin
            hour_next = {ht, ho + 4'd1};
        end
`endif
    endfunction

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;
    logic [DW-1:0] div_q, div_d;
    logic [2:0]    idx_q, idx_d;
    logic [3:0]    s_o_q, s_o_d, s_t_q, s_t_d, m_o_q, m_o_d, m_t_q, m_t_d;
    logic [3:0]    h_o_q, h_o_d, h_t_q, h_t_d;
    logic          sec_tick_q, sec_tick_d;
    logic [7:0]    cx_q, cx_d, an_q, an_d;
    logic          set_any, hour_inc, phase, dp_pos;
    logic [2:0]    pos;
    logic [3:0]    digit;
`ifdef HOUR12_EN
    logic          pm_q, pm_d;
`endif

    // Time-of-day update: set pulses win over a coincident tick.
    always_comb begin
        s_o_d      = s_o_q;
        s_t_d      = s_t_q;
        m_o_d      = m_o_q;
        m_t_d      = m_t_q;
        hour_inc   = 1'b0;
        sec_tick_d = 1'b0;
        set_any    = bus.set_min | bus.set_hour;
        if (set_any) begin
            if (bus.set_min) begin
                s_o_d = 4'd0;
                s_t_d = 4'd0;
                if (m_o_q == 4'd9) begin
                    m_o_d = 4'd0;
                    m_t_d = (m_t_q == 4'd5) ? 4'd0 : m_t_q + 4'd1;
                end else begin
                    m_o_d = m_o_q + 4'd1;
                end
            end
            hour_inc = bus.set_hour;
        end else if (tick_q && bus.run) begin
            sec_tick_d = 1'b1;
            if (s_o_q != 4'd9) begin
                s_o_d = s_o_q + 4'd1;
            end else begin
                s_o_d = 4'd0;
                if (s_t_q != 4'd5) begin
                    s_t_d = s_t_q + 4'd1;
                end else begin
                    s_t_d = 4'd0;
                    if (m_o_q != 4'd9) begin
                        m_o_d = m_o_q + 4'd1;
                    end else begin
                        m_o_d = 4'd0;
                        if (m_t_q != 4'd5) begin
                            m_t_d = m_t_q + 4'd1;
                        end else begin
                            m_t_d    = 4'd0;
                            hour_inc = 1'b1;
                        end
                    end
                end
            end
        end
        {h_t_d, h_o_d} = hour_inc ? hour_next(h_t_q, h_o_q) : {h_t_q, h_o_q};
`ifdef HOUR12_EN
        pm_d = pm_q ^ (hour_inc && h_t_q == 4'd1 && h_o_q == 4'd1);
`endif
    end

    always_comb begin
        cnt_d  = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
        tick_d = (cnt_q == CntLast);
        phase  = (cnt_q < CntHalf);
        div_d  = div_q + 1'b1;
        idx_d  = idx_q;
        if (div_q == DivLast) begin
            div_d = '0;
            idx_d = (idx_q == IdxLast) ? 3'd0 : idx_q + 3'd1;
        end
        // pos is the digit position in HH:MM:SS order counted from s_o.
        pos    = idx_q + PosOffs;
        digit  = 4'hF;
        dp_pos = 1'b0;
        case (pos)
            3'd0: digit = s_o_q;
            3'd1: digit = s_t_q;
            3'd2: begin
                digit  = m_o_q;
                dp_pos = 1'b1;
            end
            3'd3: digit = m_t_q;
            3'd4: begin
                digit  = h_o_q;
                dp_pos = 1'b1;
            end
            3'd5: digit = h_t_q;
            default: digit = 4'hF;
        endcase
        an_d = ~(8'd1 << idx_q);
        cx_d = seg7(digit);
        if (dp_pos && phase && bus.run) begin
            cx_d[7] = 1'b0;
        end
`ifdef HOUR12_EN
        if (pos == 3'd5 && h_t_q == 4'd0) begin
            cx_d = 8'hFF;
        end
        if (idx_q == IdxLast) begin
            an_d = 8'h7F;
            cx_d = pm_q ? 8'h7F : 8'hFF;
        end
`endif
    end

    always_ff @(posedge sysCLK or posedge RST) begin
        if (RST) begin
            cnt_q      <= '0;
            tick_q     <= 1'b0;
            div_q      <= '0;
            idx_q      <= 3'd0;
            s_o_q      <= 4'd0;
            s_t_q      <= 4'd0;
            m_o_q      <= 4'd0;
            m_t_q      <= 4'd0;
            h_o_q      <= HoRst;
            h_t_q      <= HtRst;
            sec_tick_q <= 1'b0;
            cx_q       <= 8'hFF;
            an_q       <= 8'hFF;
`ifdef HOUR12_EN
            pm_q       <= 1'b0;
`endif
        end else begin
            cnt_q      <= cnt_d;
            tick_q     <= tick_d;
            div_q      <= div_d;
            idx_q      <= idx_d;
            s_o_q      <= s_o_d;
            s_t_q      <= s_t_d;
            m_o_q      <= m_o_d;
            m_t_q      <= m_t_d;
            h_o_q      <= h_o_d;
            h_t_q      <= h_t_d;
            sec_tick_q <= sec_tick_d;
            cx_q       <= cx_d;
            an_q       <= an_d;
`ifdef HOUR12_EN
            pm_q       <= pm_d;
`endif
        end
    end

    assign bus.time_bcd = {h_t_q, h_o_q, m_t_q, m_o_q, s_t_q, s_o_q};
    assign bus.sec_tick = sec_tick_q;
    assign bus.Cx       = cx_q;
    assign bus.AN       = an_q;
endmodule

// File: tb/tb_bcd_clock_scan.sv
// Randomized and directed bench for bcd_clock_scan (24-hour build) with a seconds-count model.
module tb_bcd_clock_scan;
    localparam int unsigned ClkHz     = 10;
    localparam int unsigned ScanHz    = 5;
    localparam int unsigned NumDigits = 6;
    localparam int unsigned ScanDiv   = ClkHz / ScanHz;

    typedef struct {
        int          cyc;
        logic [23:0] t;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   tod = 0;   // model time as seconds since midnight
    int   cyc = 0;   // clock edges since reset release
    exp_t sbq[$];

    bcd_clock_scan_if bus ();

    bcd_clock_scan #(
        .CLK_HZ    (ClkHz),
        .SCAN_HZ   (ScanHz),
        .NUM_DIGITS(NumDigits)
    ) dut (
        .sysCLK(clk),
        .RST   (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d, t=%0d)", name, act, exp, cyc,
                     $time);
        end
    endtask

    function automatic logic [23:0] to_bcd(input int t);
        int h, m, s;
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [7:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return 8'hC0;
            4'd1:    return 8'hF9;
            4'd2:    return 8'hA4;
            4'd3:    return 8'hB0;
            4'd4:    return 8'h99;
            4'd5:    return 8'h92;
            4'd6:    return 8'h82;
            4'd7:    return 8'hF8;
            4'd8:    return 8'h80;
            4'd9:    return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // One clock: drive inputs, advance the model, then check the registered outputs.
    task automatic step(input logic run_v, input logic smin, input logic shour);
        logic [23:0] b;
        logic [7:0]  an_e, cx_e;
        int          idx, h, m, s;
        bit          tk;
        exp_t        e;
        bus.run      = run_v;
        bus.set_min  = smin;
        bus.set_hour = shour;
        b    = to_bcd(tod);
        idx  = (cyc / ScanDiv) % NumDigits;
        an_e = ~(8'd1 << idx);
        cx_e = seg_of(b[idx*4 +: 4]);
        if ((idx == 2 || idx == 4) && run_v && (cyc % ClkHz) < ClkHz / 2) cx_e[7] = 1'b0;
        tk = (cyc > 0) && (cyc % ClkHz == 0);
        if (smin || shour) begin
            h = tod / 3600;
            m = (tod / 60) % 60;
            s = tod % 60;
            if (smin) begin
                m = (m + 1) % 60;
                s = 0;
            end
            if (shour) h = (h + 1) % 24;
            tod = h * 3600 + m * 60 + s;
        end else if (tk && run_v) begin
            tod   = (tod + 1) % 86400;
            e.cyc = cyc + 1;
            e.t   = to_bcd(tod);
            sbq.push_back(e);
        end
        @(posedge clk);
        cyc++;
        #1;
        bus.set_min  = 1'b0;
        bus.set_hour = 1'b0;
        check("AN", {24'h0, bus.AN}, {24'h0, an_e});
        check("Cx", {24'h0, bus.Cx}, {24'h0, cx_e});
        check("time_bcd", {8'h0, bus.time_bcd}, {8'h0, to_bcd(tod)});
    endtask

    task automatic goto_hm(input int ht, input int mt);
        for (int i = 0; i < 30 && (tod / 3600) != ht; i++) begin
            step(1'b1, 1'b0, 1'b1);
            step(1'b1, 1'b0, 1'b0);
        end
        for (int i = 0; i < 70 && ((tod / 60) % 60) != mt; i++) begin
            step(1'b1, 1'b1, 1'b0);
            step(1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic wait_sec(input int st);
        for (int i = 0; i < 2000 && (tod % 60) != st; i++) step(1'b1, 1'b0, 1'b0);
        check("wait_sec_reached", 32'(tod % 60), 32'(st));
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1;
        rst = 1'b0;
        tod = 0;
        cyc = 0;
        sbq.delete();
    endtask

    // Scoreboard monitor: every sec_tick must match the head of the expected queue.
    always @(negedge clk) begin
        bit exp_tick;
        if (!rst) begin
            exp_tick = (sbq.size() > 0) && (sbq[0].cyc == cyc);
            if (bus.sec_tick || exp_tick) begin
                check("sec_tick", {31'h0, bus.sec_tick}, {31'h0, exp_tick});
                if (exp_tick) begin
                    check("tick_time", {8'h0, bus.time_bcd}, {8'h0, sbq[0].t});
                    void'(sbq.pop_front());
                end
            end
        end
    end

    initial begin
        int first;
        int t0;
        bus.run      = 1'b1;
        bus.set_min  = 1'b0;
        bus.set_hour = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_AN", {24'h0, bus.AN}, 32'hFF);
        check("rst_Cx", {24'h0, bus.Cx}, 32'hFF);
        check("rst_time", {8'h0, bus.time_bcd}, 32'h0);
        check("rst_sec_tick", {31'h0, bus.sec_tick}, 32'h0);
        release_rst();

        // First tick after release.
        step(1'b1, 1'b0, 1'b0);
        check("AN_first", {24'h0, bus.AN}, 32'hFE);
        first = -1;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (bus.sec_tick && first < 0) first = cyc;
        end
        check("first_tick_cycle", 32'(first), 32'd11);

        // 23:59:59 -> 00:00:00.
        goto_hm(23, 59);
        wait_sec(59);
        for (int i = 0; i < 20 && tod != 0; i++) step(1'b1, 1'b0, 1'b0);
        check("rollover_time", {8'h0, bus.time_bcd}, 32'h0);
        check("rollover_tick", {31'h0, bus.sec_tick}, 32'h1);

        // set_min at 00:59:30: minutes wrap without hour carry, seconds cleared.
        goto_hm(0, 59);
        wait_sec(30);
        step(1'b1, 1'b1, 1'b0);
        check("set_min_wrap", {8'h0, bus.time_bcd}, 32'h0);

        // set_hour coinciding with a tick at 05:10:20.
        goto_hm(5, 10);
        wait_sec(20);
        for (int i = 0; i < 20 && (cyc % ClkHz) != 0; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check("set_hour_tick", {8'h0, bus.time_bcd}, 32'h061020);
        check("set_hour_no_tick", {31'h0, bus.sec_tick}, 32'h0);

        // Frozen for 30 ticks.
        t0 = tod;
        for (int i = 0; i < 30 * ClkHz; i++) step(1'b0, 1'b0, 1'b0);
        check("frozen_time", {8'h0, bus.time_bcd}, {8'h0, to_bcd(t0)});

        // Random run / set activity.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 24) == 0),
                 1'($urandom_range(0, 24) == 0));
        end

        // Reset at prescaler count 7.
        for (int i = 0; i < 20 && (cyc % ClkHz) != 7; i++) step(1'b1, 1'b0, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_AN", {24'h0, bus.AN}, 32'hFF);
        check("midrst_Cx", {24'h0, bus.Cx}, 32'hFF);
        check("midrst_time", {8'h0, bus.time_bcd}, 32'h0);
        release_rst();
        first = -1;
        for (int i = 0; i < 15; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (bus.sec_tick && first < 0) first = cyc;
        end
        check("midrst_tick_cycle", 32'(first), 32'd11);

        step(1'b1, 1'b0, 1'b0);
        check("sb_drained", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
